// File: rtl/mv_pkg.sv
// Shared types and helpers for the matrix-vector engine.
package mv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } mv_state_t;

  // Ceiling log2 usable in constant expressions (valid for v up to 2^32).
  function automatic int unsigned mv_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: a full product plus enough headroom for COLS_MAX sums.
  function automatic int unsigned mv_rw_width(input int unsigned dw, input int unsigned cols_max);
    return 2 * dw + mv_clog2(cols_max);
  endfunction

  // Extend the low dw bits of v to 64 bits, sign- or zero-filling above.
  function automatic logic [63:0] mv_ext(input logic [63:0] v, input int unsigned dw,
                                         input logic sgn);
    logic [63:0] r;
    logic        fill;
    fill = sgn & v[dw-1];
    for (int unsigned i = 0; i < 64; i++) begin
      r[i] = (i < dw) ? v[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/mv_engine_if.sv
// Job, source-read and result-write signals of the matrix-vector engine.
interface mv_engine_if
  import mv_pkg::*;
#(
  parameter int unsigned ROWS     = 3,
  parameter int unsigned COLS_MAX = 32,
  parameter int unsigned DW       = 8,
  parameter int unsigned WAW      = 5
);
  localparam int unsigned AW = $clog2(COLS_MAX);
  localparam int unsigned RW = mv_rw_width(DW, COLS_MAX);

  // Job control
  logic           start;
  logic [AW:0]    cols;
  logic [WAW-1:0] wr_base;
  logic           signed_mode;
  logic           busy;
  logic           done;
  logic           err;
  // Source BRAM read port
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  mat_a [ROWS];
  logic [DW-1:0]  vect_b;
  // Result BRAM write port
  logic           wr_en;
  logic [WAW-1:0] wr_addr;
  logic [RW-1:0]  wr_data;

  modport master (
    output start, cols, wr_base, signed_mode, mat_a, vect_b,
    input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, cols, wr_base, signed_mode, mat_a, vect_b,
    output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/mv_mac_lane.sv
// One multiply-accumulate lane: acc += ext(a) * ext(b) at full precision.
module mv_mac_lane
  import mv_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned RW = 21
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_signed_mode,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [RW-1:0] o_acc
);

  logic [63:0]   w_a_ext;
  logic [63:0]   w_b_ext;
  logic [RW-1:0] w_prod;
  logic [RW-1:0] r_acc;

  // Extend both operands, then keep only the RW low product bits: the modular sum is exact.
  always_comb begin
    w_a_ext = mv_ext(64'(i_a), DW, i_signed_mode);
    w_b_ext = mv_ext(64'(i_b), DW, i_signed_mode);
    w_prod  = RW'(w_a_ext * w_b_ext);
  end

  // Accumulator: cleared on reset or job start, advanced on each valid beat.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mv_engine.sv
// Matrix-vector engine: y = A * b with ROWS parallel lanes and a run-time column count.
module mv_engine
  import mv_pkg::*;
#(
  parameter int unsigned ROWS     = 3,
  parameter int unsigned COLS_MAX = 32,
  parameter int unsigned DW       = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned WAW      = 5
) (
  input logic        i_clk,
  input logic        i_rst,
  mv_engine_if.slave bus
);

  localparam int unsigned AW  = $clog2(COLS_MAX);
  localparam int unsigned RW  = mv_rw_width(DW, COLS_MAX);
  localparam int unsigned DCW = $clog2(RD_LAT + 1);
  localparam int unsigned WCW = $clog2(ROWS + 1);
  localparam logic [AW:0] ColsMax = (AW + 1)'(COLS_MAX);

  mv_state_t      r_state;
  mv_state_t      w_state_d;
  logic [AW:0]    r_cols;
  logic [AW:0]    r_col;
  logic [WAW-1:0] r_wbase;
  logic           r_sm;
  logic           r_err;
  logic [DCW-1:0] r_dcnt;
  logic [WCW-1:0] r_wcnt;
  logic [RD_LAT-1:0] r_vld;

  logic           w_cols_ok;
  logic           w_start;
  logic           w_accept;
  logic           w_rd_en;
  logic [RW-1:0]  w_acc [ROWS];

  assign w_cols_ok = (bus.cols != '0) && (bus.cols <= ColsMax);
  assign w_start   = (r_state == IDLE) && bus.start;
  assign w_accept  = w_start && w_cols_ok;
  assign w_rd_en   = (r_state == READ);

  // Next-state logic; each phase ends when its counter reaches its last value.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_d = READ;
      READ:    if (r_col == (r_cols - 1'b1)) w_state_d = DRAIN;
      DRAIN:   if (r_dcnt == DCW'(RD_LAT - 1)) w_state_d = WRITE;
      WRITE:   if (r_wcnt == WCW'(ROWS - 1)) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // State register, job latches, phase counters, valid pipe and err pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cols  <= '0;
      r_col   <= '0;
      r_wbase <= '0;
      r_sm    <= 1'b0;
      r_err   <= 1'b0;
      r_dcnt  <= '0;
      r_wcnt  <= '0;
      r_vld   <= '0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_start && !w_cols_ok;
      if (w_accept) begin
        r_cols  <= bus.cols;
        r_wbase <= bus.wr_base;
        r_sm    <= bus.signed_mode;
      end
      r_col  <= (r_state == READ)  ? r_col + 1'b1  : '0;
      r_dcnt <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
      r_wcnt <= (r_state == WRITE) ? r_wcnt + 1'b1 : '0;
      // Tap r_vld[RD_LAT-1] marks the cycle the BRAM data for a read is present.
      r_vld  <= (r_vld << 1) | RD_LAT'(w_rd_en);
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    mv_mac_lane #(
      .DW (DW),
      .RW (RW)
    ) u_lane (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_clr         (w_accept),
      .i_en          (r_vld[RD_LAT-1]),
      .i_signed_mode (r_sm),
      .i_a           (bus.mat_a[r]),
      .i_b           (bus.vect_b),
      .o_acc         (w_acc[r])
    );
  end

  // Write-data mux: one lane per WRITE cycle, zero otherwise.
  always_comb begin
    bus.wr_data = '0;
    if (r_state == WRITE) bus.wr_data = w_acc[r_wcnt];
  end

  assign bus.rd_en   = w_rd_en;
  assign bus.rd_addr = r_col[AW-1:0];
  assign bus.wr_en   = (r_state == WRITE);
  assign bus.wr_addr = r_wbase + WAW'(r_wcnt);
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = (r_state == DONE);
  assign bus.err     = r_err;

endmodule

// File: tb/tb_mv_engine.sv
// Bench for mv_engine: two instances (read latency 1 and 3) run the same jobs in parallel.
module tb_mv_engine;
  import mv_pkg::*;

  localparam int unsigned ROWS     = 3;
  localparam int unsigned COLS_MAX = 32;
  localparam int unsigned DW       = 8;
  localparam int unsigned WAW      = 5;
  localparam int unsigned RW       = 21;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       start;
  logic [5:0] cols;
  logic [4:0] wr_base;
  logic       sm;

  logic [7:0] mem_a [ROWS][COLS_MAX];
  logic [7:0] mem_b [COLS_MAX];
  logic [4:0] ap0 = '0;
  logic [4:0] ap1 [3] = '{default: '0};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0    = 0;

  int n_wr [2];
  int n_rd [2];
  int n_err [2];
  int n_done [2];
  int busy_hi [2];
  int done_cyc [2];
  int err_cyc [2];
  logic [4:0]    log_addr [2][8];
  logic [RW-1:0] log_data [2][8];

  always #5 clk = ~clk;

  mv_engine_if #(.ROWS(ROWS), .COLS_MAX(COLS_MAX), .DW(DW), .WAW(WAW)) u_if0 ();
  mv_engine_if #(.ROWS(ROWS), .COLS_MAX(COLS_MAX), .DW(DW), .WAW(WAW)) u_if1 ();

  mv_engine #(.ROWS(ROWS), .COLS_MAX(COLS_MAX), .DW(DW), .RD_LAT(1), .WAW(WAW)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst[0]),
    .bus   (u_if0)
  );

  mv_engine #(.ROWS(ROWS), .COLS_MAX(COLS_MAX), .DW(DW), .RD_LAT(3), .WAW(WAW)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst[1]),
    .bus   (u_if1)
  );

  assign u_if0.start       = start;
  assign u_if0.cols        = cols;
  assign u_if0.wr_base     = wr_base;
  assign u_if0.signed_mode = sm;
  assign u_if1.start       = start;
  assign u_if1.cols        = cols;
  assign u_if1.wr_base     = wr_base;
  assign u_if1.signed_mode = sm;

  // Source BRAMs: read data appears 1 (dut0) or 3 (dut1) edges after the address.
  always @(posedge clk) begin
    ap0    <= u_if0.rd_addr;
    ap1[0] <= u_if1.rd_addr;
    ap1[1] <= ap1[0];
    ap1[2] <= ap1[1];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_bram
    assign u_if0.mat_a[r] = mem_a[r][ap0];
    assign u_if1.mat_a[r] = mem_a[r][ap1[2]];
  end
  assign u_if0.vect_b = mem_b[ap0];
  assign u_if1.vect_b = mem_b[ap1[2]];

  logic          m_rd_en [2];
  logic          m_wr_en [2];
  logic          m_busy [2];
  logic          m_done [2];
  logic          m_err [2];
  logic [4:0]    m_wr_addr [2];
  logic [RW-1:0] m_wr_data [2];

  assign m_rd_en[0]   = u_if0.rd_en;
  assign m_wr_en[0]   = u_if0.wr_en;
  assign m_busy[0]    = u_if0.busy;
  assign m_done[0]    = u_if0.done;
  assign m_err[0]     = u_if0.err;
  assign m_wr_addr[0] = u_if0.wr_addr;
  assign m_wr_data[0] = u_if0.wr_data;
  assign m_rd_en[1]   = u_if1.rd_en;
  assign m_wr_en[1]   = u_if1.wr_en;
  assign m_busy[1]    = u_if1.busy;
  assign m_done[1]    = u_if1.done;
  assign m_err[1]     = u_if1.err;
  assign m_wr_addr[1] = u_if1.wr_addr;
  assign m_wr_data[1] = u_if1.wr_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Observers: sample each instance mid-cycle and log writes, reads, pulses and busy time.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_wr_en[d] === 1'b1) begin
        if (n_wr[d] < 8) begin
          log_addr[d][n_wr[d]] = m_wr_addr[d];
          log_data[d][n_wr[d]] = m_wr_data[d];
        end
        n_wr[d]++;
      end
      if (m_rd_en[d] === 1'b1) n_rd[d]++;
      if (m_busy[d] === 1'b1) busy_hi[d]++;
      if (m_err[d] === 1'b1) begin
        n_err[d]++;
        err_cyc[d] = cyc;
      end
      if (m_done[d] === 1'b1) begin
        n_done[d]++;
        done_cyc[d] = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: y[r] = sum over columns of a*b as plain integers, reduced to RW bits.
  function automatic logic [RW-1:0] model(input int r, input int ncols, input bit smode);
    longint s;
    s = 0;
    for (int c = 0; c < ncols; c++) begin
      longint av;
      longint bv;
      av = smode ? longint'($signed(mem_a[r][c])) : longint'(mem_a[r][c]);
      bv = smode ? longint'($signed(mem_b[c])) : longint'(mem_b[c]);
      s += av * bv;
    end
    return s[RW-1:0];
  endfunction

  task automatic clr_logs();
    for (int d = 0; d < 2; d++) begin
      n_wr[d] = 0; n_rd[d] = 0; n_err[d] = 0; n_done[d] = 0;
      busy_hi[d] = 0; done_cyc[d] = 0; err_cyc[d] = 0;
      for (int i = 0; i < 8; i++) begin
        log_addr[d][i] = 'x;
        log_data[d][i] = 'x;
      end
    end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < int'(COLS_MAX); c++) begin
      for (int r = 0; r < int'(ROWS); r++) mem_a[r][c] = 8'($urandom);
      mem_b[c] = 8'($urandom);
    end
  endtask

  // Launch one job and wait (bounded) until both instances have pulsed done.
  task automatic run_job(input int ncols, input int base, input bit smode, input bit mid);
    clr_logs();
    start = 1'b1; cols = 6'(ncols); wr_base = 5'(base); sm = smode;
    tick();
    t0 = cyc;
    start = 1'b0;
    if (mid) begin
      tick();
      start = 1'b1; cols = 6'd2; wr_base = 5'(base + 7); sm = ~smode;
      tick();
      start = 1'b0;
    end
    for (int k = 0; k < 300; k++) begin
      if (n_done[0] != 0 && n_done[1] != 0) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    start = 1'b0; cols = '0; wr_base = '0; sm = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({m_rd_en[d], m_wr_en[d], m_busy[d], m_done[d], m_err[d]} !== 5'b0) begin
        fails++;
        $display("FAIL reset_ctrl dut%0d: got rd/wr/busy/done/err=%b expected 00000", d,
                 {m_rd_en[d], m_wr_en[d], m_busy[d], m_done[d], m_err[d]});
      end
      tests++;
      if (m_wr_data[d] !== '0) begin
        fails++;
        $display("FAIL reset_wr_data dut%0d: got %0d expected 0", d, m_wr_data[d]);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [RW-1:0] exp_y [3];
    exp_y = '{21'd6, 21'd15, 21'd24};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) mem_a[r][c] = 8'(3 * r + c + 1);
      mem_b[r] = 8'd1;
    end
    run_job(3, 0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (n_done[d] !== 1 || done_cyc[d] - t0 !== 3 + lat_of(d) + 3) begin
        fails++;
        $display("FAIL basic_latency dut%0d: got %0d pulses at +%0d expected 1 at +%0d", d,
                 n_done[d], done_cyc[d] - t0, 3 + lat_of(d) + 3);
      end
      tests++;
      if (n_wr[d] !== 3) begin
        fails++;
        $display("FAIL basic_nwr dut%0d: got %0d expected 3", d, n_wr[d]);
      end
      for (int r = 0; r < 3; r++) begin
        tests++;
        if (log_addr[d][r] !== 5'(r) || log_data[d][r] !== exp_y[r]) begin
          fails++;
          $display("FAIL basic_row%0d dut%0d: got @%0d=%0d expected @%0d=%0d", r, d,
                   log_addr[d][r], log_data[d][r], r, exp_y[r]);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [RW-1:0] exp_row0;
    fill_rand();
    mem_a[0][0] = 8'hFF; mem_a[0][1] = 8'h80;
    mem_b[0] = 8'h02; mem_b[1] = 8'h7F;
    for (int mode = 1; mode >= 0; mode--) begin
      exp_row0 = (mode == 1) ? RW'(-16258) : RW'(16766);
      run_job(2, 5, mode[0], 1'b0);
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (log_data[d][0] !== exp_row0) begin
          fails++;
          $display("FAIL signed_row0 mode%0d dut%0d: got %0d expected %0d", mode, d,
                   log_data[d][0], exp_row0);
        end
        for (int r = 1; r < 3; r++) begin
          tests++;
          if (log_data[d][r] !== model(r, 2, mode[0]) || log_addr[d][r] !== 5'(5 + r)) begin
            fails++;
            $display("FAIL signed_row%0d mode%0d dut%0d: got @%0d=%0d expected @%0d=%0d", r,
                     mode, d, log_addr[d][r], log_data[d][r], 5 + r, model(r, 2, mode[0]));
          end
        end
      end
    end
  endtask

  task automatic test_err();
    int bad [2];
    bad = '{0, int'(COLS_MAX) + 1};
    for (int i = 0; i < 2; i++) begin
      clr_logs();
      start = 1'b1; cols = 6'(bad[i]); wr_base = 5'd3; sm = 1'b0;
      tick();
      t0 = cyc;
      start = 1'b0;
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (n_err[d] !== 1 || err_cyc[d] !== t0) begin
          fails++;
          $display("FAIL err_pulse cols=%0d dut%0d: got %0d pulses at +%0d expected 1 at +0",
                   bad[i], d, n_err[d], err_cyc[d] - t0);
        end
        tests++;
        if (n_rd[d] !== 0 || n_wr[d] !== 0 || busy_hi[d] !== 0) begin
          fails++;
          $display("FAIL err_quiet cols=%0d dut%0d: got rd=%0d wr=%0d busy=%0d expected 0/0/0",
                   bad[i], d, n_rd[d], n_wr[d], busy_hi[d]);
        end
      end
    end
  endtask

  task automatic test_full();
    for (int c = 0; c < int'(COLS_MAX); c++) begin
      for (int r = 0; r < int'(ROWS); r++) mem_a[r][c] = 8'hFF;
      mem_b[c] = 8'hFF;
    end
    run_job(32, 0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (n_done[d] !== 1 || done_cyc[d] - t0 !== 32 + lat_of(d) + 3 || n_rd[d] !== 32) begin
        fails++;
        $display("FAIL full_timing dut%0d: got done@+%0d rd=%0d expected done@+%0d rd=32", d,
                 done_cyc[d] - t0, n_rd[d], 32 + lat_of(d) + 3);
      end
      for (int r = 0; r < 3; r++) begin
        tests++;
        if (log_data[d][r] !== 21'd2080800) begin
          fails++;
          $display("FAIL full_row%0d dut%0d: got %0d expected 2080800", r, d, log_data[d][r]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_a [3];
    exp_a = '{5'd30, 5'd31, 5'd0};
    fill_rand();
    run_job(4, 30, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 3; r++) begin
        tests++;
        if (log_addr[d][r] !== exp_a[r] || log_data[d][r] !== model(r, 4, 1'b0)) begin
          fails++;
          $display("FAIL wrap_row%0d dut%0d: got @%0d=%0d expected @%0d=%0d", r, d,
                   log_addr[d][r], log_data[d][r], exp_a[r], model(r, 4, 1'b0));
        end
      end
    end
  endtask

  task automatic test_mid_start();
    fill_rand();
    run_job(8, 3, 1'b1, 1'b1);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (n_rd[d] !== 8 || n_wr[d] !== 3 || n_done[d] !== 1) begin
        fails++;
        $display("FAIL mid_counts dut%0d: got rd=%0d wr=%0d done=%0d expected 8/3/1", d,
                 n_rd[d], n_wr[d], n_done[d]);
      end
      for (int r = 0; r < 3; r++) begin
        tests++;
        if (log_addr[d][r] !== 5'(3 + r) || log_data[d][r] !== model(r, 8, 1'b1)) begin
          fails++;
          $display("FAIL mid_row%0d dut%0d: got @%0d=%0d expected @%0d=%0d", r, d,
                   log_addr[d][r], log_data[d][r], 3 + r, model(r, 8, 1'b1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit [2];
    fill_rand();
    clr_logs();
    start = 1'b1; cols = 6'd5; wr_base = 5'd10; sm = 1'b0;
    tick();
    start = 1'b0;
    // Assert reset during each instance's first WRITE cycle; check outputs one edge later.
    for (int k = 0; k < 100; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (rst[d]) begin
          tests++;
          if ({m_rd_en[d], m_wr_en[d], m_busy[d], m_done[d], m_err[d]} !== 5'b0 ||
              m_wr_data[d] !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs dut%0d: got ctrl=%b data=%0d expected 00000 and 0", d,
                     {m_rd_en[d], m_wr_en[d], m_busy[d], m_done[d], m_err[d]}, m_wr_data[d]);
          end
          rst[d] = 1'b0;
        end else if (!hit[d] && m_wr_en[d] === 1'b1) begin
          rst[d] = 1'b1;
          hit[d] = 1'b1;
        end
      end
      if (hit[0] && hit[1] && !rst[0] && !rst[1]) break;
      tick();
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (n_wr[d] !== 1 || n_done[d] !== 0) begin
        fails++;
        $display("FAIL rstmid_writes dut%0d: got wr=%0d done=%0d expected 1/0", d, n_wr[d],
                 n_done[d]);
      end
    end
    fill_rand();
    run_job(7, 20, 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 3; r++) begin
        tests++;
        if (log_addr[d][r] !== 5'(20 + r) || log_data[d][r] !== model(r, 7, 1'b1)) begin
          fails++;
          $display("FAIL rstmid_next_row%0d dut%0d: got @%0d=%0d expected @%0d=%0d", r, d,
                   log_addr[d][r], log_data[d][r], 20 + r, model(r, 7, 1'b1));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      int  nc;
      int  base;
      bit  smode;
      nc    = int'($urandom_range(1, COLS_MAX));
      base  = int'($urandom_range(0, 31));
      smode = 1'($urandom);
      fill_rand();
      run_job(nc, base, smode, 1'b0);
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (n_done[d] !== 1 || done_cyc[d] - t0 !== nc + lat_of(d) + 3 || n_wr[d] !== 3 ||
            n_rd[d] !== nc) begin
          fails++;
          $display("FAIL rand%0d_timing dut%0d: got done=%0d@+%0d wr=%0d rd=%0d expected 1@+%0d 3 %0d",
                   j, d, n_done[d], done_cyc[d] - t0, n_wr[d], n_rd[d], nc + lat_of(d) + 3, nc);
        end
        for (int r = 0; r < 3; r++) begin
          tests++;
          if (log_addr[d][r] !== 5'(base + r) || log_data[d][r] !== model(r, nc, smode)) begin
            fails++;
            $display("FAIL rand%0d_row%0d dut%0d: got @%0d=%0d expected @%0d=%0d", j, r, d,
                     log_addr[d][r], log_data[d][r], 5'(base + r), model(r, nc, smode));
          end
        end
      end
    end
  endtask

  initial begin
    clr_logs();
    test_reset();
    test_basic();
    test_signed();
    test_err();
    test_full();
    test_wrap();
    test_mid_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
